// File: rtl/frame_buf_pkg.sv
// Shared definitions for the packet buffer read engine.
//   fb_state_t        : read FSM state encoding (IDLE / READ / DRAIN)
//   DEFAULT_LEN_WIDTH : default width of the frame length field, in words
package frame_buf_pkg;

    localparam int DEFAULT_LEN_WIDTH = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } fb_state_t;

endpackage

// File: rtl/stream_skid_fifo2.sv
// Two-entry register FIFO with a valid/ready output side.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data this cycle (caller guarantees space)
//   push_data  : entry to store
//   out_valid  : head entry present
//   out_ready  : consumer accepts head this cycle
//   out_data   : head entry
//   pop        : head handshake this cycle (out_valid & out_ready)
//   count      : current occupancy, 0..2
module stream_skid_fifo2 #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             pop,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic [1:0]       count_q;

    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_q;
    assign pop       = out_valid & out_ready;
    assign count     = count_q;

    // The head register is the output, so it only changes on a pop or when
    // the FIFO is empty; this keeps out_data stable under back-pressure.
    // A push into a full FIFO without a pop is excluded by the caller's credit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) head_q <= push_data;
                    else                 tail_q <= push_data;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    head_q  <= tail_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_q <= push_data;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/frame_buffer_reader.sv
// Read-side engine of the switch packet buffer. Takes a frame descriptor
// (start address, length in words), issues sequential reads on the RAM read
// port (1-cycle latency), and emits the frame as a valid/ready stream with last.
//   clk, rst_n              : clock (RAM read clock), asynchronous active-low reset
//   desc_valid/ready/addr/len: descriptor input
//   rden, read_addr, read_data: RAM read port
//   m_valid/ready/data/last  : output word stream
//   free_valid, free_count   : pulse when a frame is fully delivered, with its length
//   addr_err                 : pulse after a descriptor with out-of-range address is dropped
//   busy                     : engine not idle
//   state_dbg                : current FSM state
//
// Handshake semantics (all interfaces): a transfer happens on a rising edge
// where valid and ready are both 1; valid never drops and the payload never
// changes until that transfer has happened.
module frame_buffer_reader
    import frame_buf_pkg::*;
#(
    parameter int WORD_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter int LEN_WIDTH  = DEFAULT_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  desc_valid,
    output logic                  desc_ready,
    input  logic [ADDR_WIDTH-1:0] desc_addr,
    input  logic [LEN_WIDTH-1:0]  desc_len,
    output logic                  rden,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [WORD_WIDTH-1:0] read_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [WORD_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  free_valid,
    output logic [LEN_WIDTH-1:0]  free_count,
    output logic                  addr_err,
    output logic                  busy,
    output fb_state_t             state_dbg
);

    localparam logic [31:0]           DEPTH_U  = 32'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = 1;

    fb_state_t             state, state_nxt;
    logic                  armed;        // low only until the first edge after reset
    logic [ADDR_WIDTH-1:0] ptr;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  issue_cnt;
    logic                  rd_pending;   // a read was issued last cycle; data is on read_data now
    logic                  rd_last;      // that read was the final word of the frame
    logic                  addr_err_q;

    logic                  desc_hs;
    logic                  addr_bad;
    logic                  desc_take;
    logic                  issue_last;
    logic [2:0]            occupancy;
    logic                  credit_ok;
    logic                  fifo_pop;
    logic [1:0]            fifo_count;
    logic [WORD_WIDTH:0]   fifo_out;
    logic                  last_hs;

    assign desc_ready = (state == ST_IDLE) && armed;
    assign desc_hs    = desc_valid && desc_ready;
    assign addr_bad   = (32'(desc_addr) >= DEPTH_U);
    assign desc_take  = desc_hs && !addr_bad && (desc_len != '0);
    assign issue_last = (issue_cnt == len_q - LEN_ONE);

    // Words already owned by the skid FIFO, plus the one on its way from RAM,
    // minus the one leaving now. Issuing only below 2 means the 2-entry FIFO
    // can always absorb every read in flight.
    assign occupancy = {1'b0, fifo_count} + {2'b00, rd_pending} - {2'b00, fifo_pop};
    assign credit_ok = (occupancy < 3'd2);

    assign last_hs   = fifo_pop && fifo_out[WORD_WIDTH];

    always_comb begin
        state_nxt  = state;
        rden       = 1'b0;
        free_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (desc_take) state_nxt = ST_READ;
            end
            ST_READ: begin
                rden = credit_ok;
                if (credit_ok && issue_last) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (last_hs) begin
                    free_valid = 1'b1;
                    state_nxt  = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            armed      <= 1'b0;
            ptr        <= '0;
            len_q      <= '0;
            issue_cnt  <= '0;
            rd_pending <= 1'b0;
            rd_last    <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            armed      <= 1'b1;
            rd_pending <= rden;
            rd_last    <= rden && issue_last;
            addr_err_q <= desc_hs && addr_bad;
            if (desc_take) begin
                ptr       <= desc_addr;
                len_q     <= desc_len;
                issue_cnt <= '0;
            end else if (rden) begin
                // DEPTH need not be a power of two, so wrap explicitly
                ptr       <= (32'(ptr) == DEPTH_U - 32'd1) ? '0 : ptr + ADDR_ONE;
                issue_cnt <= issue_cnt + LEN_ONE;
            end
        end
    end

    stream_skid_fifo2 #(
        .WIDTH (WORD_WIDTH + 1)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_pending),
        .push_data ({rd_last, read_data}),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .out_data  (fifo_out),
        .pop       (fifo_pop),
        .count     (fifo_count)
    );

    assign m_last     = fifo_out[WORD_WIDTH];
    assign m_data     = fifo_out[WORD_WIDTH-1:0];
    assign read_addr  = ptr;
    assign free_count = free_valid ? len_q : '0;
    assign addr_err   = addr_err_q;
    assign busy       = (state != ST_IDLE);
    assign state_dbg  = state;

endmodule

// File: tb/tb_frame_buffer_reader.sv
module tb_frame_buffer_reader;
    import frame_buf_pkg::*;

    localparam int WW    = 8;
    localparam int AW    = 9;   // wide enough to present an out-of-range address
    localparam int DEPTH = 256;
    localparam int LW    = 12;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          desc_valid = 1'b0;
    logic          desc_ready;
    logic [AW-1:0] desc_addr = '0;
    logic [LW-1:0] desc_len = '0;
    logic          rden;
    logic [AW-1:0] read_addr;
    logic [WW-1:0] read_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [WW-1:0] m_data;
    logic          m_last;
    logic          free_valid;
    logic [LW-1:0] free_count;
    logic          addr_err;
    logic          busy;
    fb_state_t     state_dbg;

    frame_buffer_reader #(
        .WORD_WIDTH (WW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .desc_valid (desc_valid),
        .desc_ready (desc_ready),
        .desc_addr  (desc_addr),
        .desc_len   (desc_len),
        .rden       (rden),
        .read_addr  (read_addr),
        .read_data  (read_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .free_valid (free_valid),
        .free_count (free_count),
        .addr_err   (addr_err),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    // ---------------- RAM model (1-cycle read latency) ----------------
    function automatic logic [WW-1:0] ram_val(input int a);
        return WW'((a * 37 + 11) ^ (a >> 3));
    endfunction

    logic [WW-1:0] ram [0:(1<<AW)-1];
    initial for (int i = 0; i < (1 << AW); i++) ram[i] = ram_val(i);
    always @(posedge clk) if (rden) read_data <= ram[read_addr];

    // ---------------- scoreboard state ----------------
    logic [WW:0]   exp_q[$];    // {last, data} per expected beat
    logic [AW-1:0] addr_q[$];   // expected read address sequence
    logic [LW-1:0] flen_q[$];   // expected free_count per frame
    int            beat_cyc_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int beats_seen = 0;
    int issued = 0;
    int popped = 0;
    int ready_mode = 0;
    int ready_phase = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // ---------------- downstream ready driver ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: begin
                    m_ready = (ready_phase == 0);
                    ready_phase = (ready_phase + 1) % 3;
                end
                2: m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b1;
            endcase
        end
    end

    // ---------------- monitor ----------------
    logic        prev_stall = 1'b0;
    logic [WW:0] prev_beat = '0;

    always @(negedge clk) begin
        logic [WW:0] e;
        if (!rst_n) begin
            prev_stall = 1'b0;
            issued = 0;
            popped = 0;
        end else begin
            if (prev_stall) begin
                check_val("stall_valid", 32'(m_valid), 32'd1);
                check_val("stall_data", 32'({m_last, m_data}), 32'(prev_beat));
            end
            if (rden) begin
                check_val("occupancy_le2",
                          32'((issued + 1 - popped - ((m_valid && m_ready) ? 1 : 0)) <= 2), 32'd1);
                if (addr_q.size() == 0) check_val("rden_unexpected", 32'd1, 32'd0);
                else check_val("read_addr", 32'(read_addr), 32'(addr_q.pop_front()));
                issued++;
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("beat_unexpected", 32'({m_last, m_data}), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check_val("beat", 32'({m_last, m_data}), 32'(e));
                    if (e[WW]) begin
                        check_val("free_valid", 32'(free_valid), 32'd1);
                        if (flen_q.size() != 0)
                            check_val("free_count", 32'(free_count), 32'(flen_q.pop_front()));
                    end else begin
                        check_val("free_early", 32'(free_valid), 32'd0);
                    end
                end
                popped++;
                beats_seen++;
                beat_cyc_q.push_back(cyc);
            end else if (free_valid) begin
                check_val("free_spurious", 32'd1, 32'd0);
            end
            prev_stall = m_valid && !m_ready;
            prev_beat  = {m_last, m_data};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_desc(input int addr, input int len);
        int waited = 0;
        @(negedge clk);
        while (!desc_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!desc_ready) begin
            check_val("desc_ready_timeout", 32'd0, 32'd1);
            return;
        end
        desc_valid = 1'b1;
        desc_addr  = AW'(addr);
        desc_len   = LW'(len);
        if (addr < DEPTH && len > 0) begin
            for (int i = 0; i < len; i++) begin
                int a = (addr + i) % DEPTH;
                addr_q.push_back(AW'(a));
                exp_q.push_back({(i == len - 1), ram_val(a)});
            end
            flen_q.push_back(LW'(len));
        end
        @(posedge clk);
        #1;
        desc_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_val("frame_done", 32'(exp_q.size() == 0 && !busy), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_desc_ready"}, 32'(desc_ready), 32'd0);
        check_val({tag, "_rden"}, 32'(rden), 32'd0);
        check_val({tag, "_read_addr"}, 32'(read_addr), 32'd0);
        check_val({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        check_val({tag, "_m_data"}, 32'(m_data), 32'd0);
        check_val({tag, "_m_last"}, 32'(m_last), 32'd0);
        check_val({tag, "_free_valid"}, 32'(free_valid), 32'd0);
        check_val({tag, "_free_count"}, 32'(free_count), 32'd0);
        check_val({tag, "_addr_err"}, 32'(addr_err), 32'd0);
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_state"}, 32'(state_dbg), 32'(ST_IDLE));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int base;
        int n;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("ready_after_reset", 32'(desc_ready), 32'd1);

        // 1: basic frame, latency and throughput
        beat_cyc_q.delete();
        send_desc(16, 4);
        @(negedge clk);
        check_val("lat_first_rden", 32'(rden), 32'd1);
        check_val("lat_c1_mvalid", 32'(m_valid), 32'd0);
        check_val("busy_in_frame", 32'(busy), 32'd1);
        check_val("desc_ready_busy", 32'(desc_ready), 32'd0);
        @(negedge clk);
        check_val("lat_c2_mvalid", 32'(m_valid), 32'd0);
        @(negedge clk);
        check_val("lat_c3_mvalid", 32'(m_valid), 32'd1);
        wait_done(50);
        check_val("t1_beats", 32'(beat_cyc_q.size()), 32'd4);
        if (beat_cyc_q.size() == 4)
            check_val("t1_no_bubbles", 32'(beat_cyc_q[3] - beat_cyc_q[0]), 32'd3);

        // 2: address wrap 254,255,0,1
        send_desc(254, 4);
        wait_done(50);

        // 3: back-pressure pattern 1,0,0
        ready_mode = 1;
        ready_phase = 0;
        send_desc(8'h40, 8);
        wait_done(200);
        ready_mode = 0;

        // 4: single-word frame, then zero-length descriptor
        send_desc(8'h80, 1);
        wait_done(50);
        send_desc(8'h90, 0);
        @(negedge clk);
        check_val("len0_desc_ready", 32'(desc_ready), 32'd1);
        check_val("len0_busy", 32'(busy), 32'd0);
        repeat (6) @(negedge clk);
        check_val("len0_still_idle", 32'(busy), 32'd0);

        // 5: out-of-range address
        send_desc(300, 3);
        check_val("addr_err_pulse", 32'(addr_err), 32'd1);
        check_val("addr_err_idle", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check_val("addr_err_one_cycle", 32'(addr_err), 32'd0);
        repeat (4) @(negedge clk);

        // 6: reset after beat 2 of a 6-word frame
        base = beats_seen;
        send_desc(8'h20, 6);
        n = 0;
        while (beats_seen < base + 2 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_val("t6_two_beats", 32'(beats_seen - base), 32'd2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        addr_q.delete();
        flen_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_desc(8'h30, 2);
        wait_done(50);

        // 7: random frames under random back-pressure
        ready_mode = 2;
        for (int k = 0; k < 8; k++) begin
            send_desc($urandom_range(0, DEPTH - 1), $urandom_range(1, 10));
            wait_done(300);
        end
        ready_mode = 0;

        repeat (5) @(negedge clk);
        check_val("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check_val("addr_q_empty", 32'(addr_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
